// File: rtl/alu_rr_arbiter.sv
// Two-client round-robin front end for one shared simple_alu.
// One operation in flight; the result is held until its owner takes it.

module simple_alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        case (op)
            3'b000: y = a + b;
            3'b001: y = a - b;
            3'b010: y = a << b[2:0];
            3'b011: y = a >> b[2:0];
            3'b100: y = a & b;
            3'b101: y = a | b;
            3'b110: y = a ^ b;
            3'b111: y = {7'd0, a == b};
            default: y = 8'h00;
        endcase
    end
endmodule

module alu_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_a_i,
    input  logic [7:0] req0_b_i,
    input  logic [2:0] req0_op_i,
    output logic       req0_ready_o,
    output logic       rsp0_valid_o,
    output logic [7:0] rsp0_data_o,
    input  logic       rsp0_ready_i,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_a_i,
    input  logic [7:0] req1_b_i,
    input  logic [2:0] req1_op_i,
    output logic       req1_ready_o,
    output logic       rsp1_valid_o,
    output logic [7:0] rsp1_data_o,
    input  logic       rsp1_ready_i,
    output logic       busy_o
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic       prio_q;
    logic       gnt_q;
    logic [7:0] a_q, b_q;
    logic [2:0] op_q;
    logic [7:0] result_q;
    logic [7:0] alu_y;

    logic       pick0, pick1;
    logic       accept, sel, rsp_fire;

    simple_alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    // prio_q only matters when both clients are valid
    assign pick0 = req0_valid_i & (~req1_valid_i | ~prio_q);
    assign pick1 = req1_valid_i & (~req0_valid_i | prio_q);

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        sel          = 1'b0;
        rsp_fire     = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (pick0 || pick1)) begin
                    accept       = 1'b1;
                    sel          = pick1;
                    req0_ready_o = pick0;
                    req1_ready_o = pick1;
                    state_d      = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_fire = gnt_q ? rsp1_ready_i : rsp0_ready_i;
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'b000;
            result_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q <= sel;
                a_q   <= sel ? req1_a_i : req0_a_i;
                b_q   <= sel ? req1_b_i : req0_b_i;
                op_q  <= sel ? req1_op_i : req0_op_i;
            end
            if (state_q == EXEC) begin
                result_q <= alu_y;
            end
            if (rsp_fire) begin
                prio_q <= ~gnt_q;
            end
        end
    end

    assign rsp0_valid_o = (state_q == RESP) & ~gnt_q;
    assign rsp1_valid_o = (state_q == RESP) & gnt_q;
    assign rsp0_data_o  = result_q;
    assign rsp1_data_o  = result_q;
    assign busy_o       = (state_q != IDLE);

endmodule
